// File: rtl/alu_flags_unit.sv
// Architectural flags register behind the 8-bit ALU: latches {O,S,C,Z}, feeds carry back for
// multi-byte chains, evaluates branch conditions and supports save/restore over the data bus.
module alu_flags_unit #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] alu_flags,
    input  logic       we,
    input  logic       chain,
    output logic       carry_to_alu,
    input  logic       clc,
    input  logic       stc,
    input  logic [7:0] bus_in,
    input  logic       load,
    input  logic       oe_n,
    output logic [7:0] bus_out,
    input  logic [2:0] cond,
    input  logic       cond_inv,
    output logic       cond_true,
    output logic [3:0] flags
);

    logic [3:0] flags_q;
    logic       chain_active;
    logic       sel;

    // A chained byte only ANDs zero when a low byte has been latched since reset or load;
    // otherwise it behaves as a fresh first byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q      <= RESET_FLAGS;
            chain_active <= 1'b0;
        end else if (load) begin
            flags_q      <= bus_in[3:0];
            chain_active <= 1'b0;
        end else if (we) begin
            if (chain && chain_active) begin
                flags_q <= {alu_flags[3:1], alu_flags[0] & flags_q[0]};
            end else begin
                flags_q <= alu_flags;
            end
            chain_active <= 1'b1;
        end else if (stc || clc) begin
            if (stc && clc) begin
                flags_q[1] <= ~flags_q[1];
            end else begin
                flags_q[1] <= stc;
            end
        end
    end

    always_comb begin
        sel = 1'b0;
        case (cond)
            3'd0: sel = flags_q[0];
            3'd1: sel = flags_q[1];
            3'd2: sel = flags_q[2];
            3'd3: sel = flags_q[3];
            3'd4: sel = flags_q[2] ^ flags_q[3];
            3'd5: sel = (flags_q[2] ^ flags_q[3]) | flags_q[0];
            3'd6: sel = flags_q[1] | flags_q[0];
            3'd7: sel = 1'b1;
            default: sel = 1'b0;
        endcase
    end

    // Carry comes from the stored register, never the in-flight ALU flags, to avoid a loop.
    assign carry_to_alu = chain & flags_q[1];
    assign cond_true    = cond_inv ^ sel;
    assign flags        = flags_q;
    assign bus_out      = oe_n ? 8'bzzzzzzzz : {4'b0000, flags_q};

endmodule

// File: doc/alu_flags_unit.md
Name: alu_flags_unit

Overview:
- Stage directly downstream of the 8-bit ALU. It latches the ALU's 4-bit flag vector {overflow, sign, carry, zero} into an architectural flags register.
- Feeds the stored carry back to the ALU carry_in so that multi-byte add/sub/shift chains work.
- Accumulates zero across chained bytes and evaluates branch conditions for the control unit.
- Lets software save and restore the flags through the 8-bit data bus, with a tri-state read driver whose active-low OE matches the ALU's.

Parameters:
- RESET_FLAGS, 4'b0000, value loaded into the flags register on reset. Bit order is [3]=O, [2]=S, [1]=C, [0]=Z.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- alu_flags  input  4  flag vector from ALU: [0]=zero, [1]=carry, [2]=sign, [3]=overflow
- we  input  1  latch alu_flags at this edge
- chain  input  1  current ALU byte is a continuation of a multi-byte operation
- carry_to_alu  output  1  drives ALU carry_in
- clc  input  1  clear stored carry
- stc  input  1  set stored carry
- bus_in  input  8  data bus, used for flags restore
- load  input  1  load flags from bus_in[3:0]
- oe_n  input  1  active-low bus output enable
- bus_out  output  8  {4'b0000, O, S, C, Z} when oe_n=0, else 8'bzzzzzzzz
- cond  input  3  condition select
- cond_inv  input  1  invert selected condition
- cond_true  output  1  combinational branch-taken result
- flags  output  4  current register contents, for debug and the control unit

Behaviour:
- Reset:
  - rst=1 at an edge sets flags := RESET_FLAGS and chain_active := 0.
  - Outputs follow combinationally: carry_to_alu=0, cond_true per cond/cond_inv on the reset value.
  - bus_out stays governed by oe_n even during reset.
  - rst overrides every other input in the same cycle.
- Update priority per edge: rst > load > we > (stc/clc). Lower-priority requests in the same cycle are dropped, not deferred.
- load: flags := bus_in[3:0]; bus_in[7:4] is ignored; chain_active := 0.
- we with chain=0:
  - flags := alu_flags.
  - chain_active := 1 (marks the low byte of a potential chain).
- we with chain=1:
  - O, S, C := alu_flags[3], [2], [1].
  - Z := alu_flags[0] & Z_old (sticky zero across bytes).
  - chain_active stays 1.
- chain=1 with chain_active=0 (no preceding byte since reset or load): treated exactly as chain=0. This is an explicit boundary case.
- stc/clc without load/we: stc=1 sets C to 1, clc=1 clears C to 0. stc and clc asserted together toggle C. Neither changes chain_active.
- carry_to_alu: combinational, equals chain & C.
  - C is the register value, not the in-flight alu_flags, so there is no combinational loop through the ALU.
  - With chain=0 it is 0; a first-byte carry-in must come from stc plus chain=1.
- cond_true = cond_inv XOR sel, where sel by cond:
  - 0: Z
  - 1: C
  - 2: S
  - 3: O
  - 4: S^O (signed less)
  - 5: (S^O)|Z (signed less-or-equal)
  - 6: C|Z
  - 7: 1 (always)
- cond_true is a function of the register only. A flag written at edge N is visible to the condition from edge N onward, i.e. latency 1 cycle after we.
- bus_out: combinational from the register. A read (oe_n=0) concurrent with load returns the old value until the edge.
- No X propagation: every register bit is defined after the first reset edge.

Test Plan:
- Reset with RESET_FLAGS=4'b0000: rst=1 for one edge while we=1, alu_flags=4'hF -> flags=4'h0, carry_to_alu=0, cond=7/cond_inv=0 gives cond_true=1.
- 16-bit add chain:
  - Byte 0: we=1, chain=0, alu_flags=4'b0011 (C=1, Z=1) -> flags=4'b0011.
  - Next cycle, chain=1 -> carry_to_alu=1.
  - Byte 1: we=1, chain=1, alu_flags=4'b0000 -> flags=4'b0000 (Z cleared by sticky AND).
- Sticky zero: two chained bytes both with alu_flags=4'b0001 -> Z=1, cond=0 gives cond_true=1. Repeat with a first byte Z=0 -> Z=0 after the second byte.
- Priority: load=1, bus_in=8'hA9, we=1, stc=1 in the same cycle -> flags=4'h9. Next cycle with oe_n=0 -> bus_out=8'h09. With oe_n=1 -> bus_out=8'hzz.
- Conditions: flags=4'b1000 (O=1, S=0) -> cond=4 gives cond_true=1; cond=4 with cond_inv=1 gives 0; cond=6 gives 0. After stc -> cond=6 gives 1.
- stc and clc together on C=0 -> C=1; repeated -> C=0. A mid-chain reset (rst during chain=1) clears chain_active, so the next chain=1 byte overwrites Z instead of ANDing.
